// File: rtl/demux_dispatcher_if.sv
// Handshake and demultiplexer-side bus of demux_dispatcher.
// slave: the dispatcher. master: the upstream stream source / observer.
// Optional macro DISPATCH_STATS_EN adds the per-destination frame counters.
interface demux_dispatcher_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              hold;
  logic [DATA_W-1:0] data;
  logic [1:0]        sel;
  logic              enable;
  logic              busy;
  logic              frame_done;
  logic              timeout_err;
`ifdef DISPATCH_STATS_EN
  logic [15:0]       frames_a;
  logic [15:0]       frames_b;
  logic [15:0]       frames_c;
  logic [15:0]       frames_d;

  modport slave (
    input  in_data, in_valid, hold,
    output in_ready, data, sel, enable, busy, frame_done, timeout_err,
    output frames_a, frames_b, frames_c, frames_d
  );
  modport master (
    output in_data, in_valid, hold,
    input  in_ready, data, sel, enable, busy, frame_done, timeout_err,
    input  frames_a, frames_b, frames_c, frames_d
  );
`else
  modport slave (
    input  in_data, in_valid, hold,
    output in_ready, data, sel, enable, busy, frame_done, timeout_err
  );
  modport master (
    output in_data, in_valid, hold,
    input  in_ready, data, sel, enable, busy, frame_done, timeout_err
  );
`endif
endinterface

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: parses framed byte stream (header = {LEN[7:2], dest[1:0]})
// and drives the 4-way demultiplexer one payload byte per cycle, holding sel
// for the whole frame. Stalled frames are aborted after TIMEOUT_CYC idle cycles.
// Optional macro DISPATCH_STATS_EN adds saturating per-destination frame counters.
module demux_dispatcher #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  demux_dispatcher_if.slave  bus
);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT_CYC);

  state_t            state;
  logic [5:0]        len_cnt;
  logic [TO_W-1:0]   stall_cnt;
  logic [TO_W:0]     stall_inc;
  logic              xfer;
  logic [DATA_W-1:0] data_r;
  logic [1:0]        sel_r;
  logic              enable_r;
  logic              busy_r;
  logic              done_r;
  logic              tmo_r;

  assign bus.in_ready    = !bus.hold && !rst_i;
  assign xfer            = bus.in_valid && bus.in_ready;
  assign stall_inc       = {1'b0, stall_cnt} + 1'b1;

  assign bus.data        = data_r;
  assign bus.sel         = sel_r;
  assign bus.enable      = enable_r;
  assign bus.busy        = busy_r;
  assign bus.frame_done  = done_r;
  assign bus.timeout_err = tmo_r;

  // Frame FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      len_cnt   <= '0;
      stall_cnt <= '0;
      data_r    <= '0;
      sel_r     <= '0;
      enable_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      tmo_r     <= 1'b0;
    end else begin
      enable_r <= 1'b0;
      done_r   <= 1'b0;
      tmo_r    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            sel_r     <= bus.in_data[1:0];
            len_cnt   <= bus.in_data[7:2];
            stall_cnt <= '0;
            if (bus.in_data[7:2] == 6'd0) begin
              done_r <= 1'b1;
            end else begin
              state  <= PAYLOAD;
              busy_r <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            data_r    <= bus.in_data;
            enable_r  <= 1'b1;
            stall_cnt <= '0;
            len_cnt   <= len_cnt - 6'd1;
            if (len_cnt == 6'd1) begin
              done_r <= 1'b1;
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end else if (TIMEOUT_CYC != 0) begin
            // Abort happens on the cycle the count would reach the limit,
            // so the counter itself never exceeds TIMEOUT_CYC-1.
            if (stall_inc == TO_LIM) begin
              tmo_r     <= 1'b1;
              state     <= IDLE;
              busy_r    <= 1'b0;
              stall_cnt <= '0;
              len_cnt   <= '0;
            end else begin
              stall_cnt <= stall_inc[TO_W-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;

  assign bus.frames_a = cnt_a;
  assign bus.frames_b = cnt_b;
  assign bus.frames_c = cnt_c;
  assign bus.frames_d = cnt_d;

  // Count completed frames per destination; sel_r still names the finished
  // frame while its done pulse is high, even if a new header lands that edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_a <= '0;
      cnt_b <= '0;
      cnt_c <= '0;
      cnt_d <= '0;
    end else if (done_r) begin
      unique case (sel_r)
        2'd0: if (cnt_a != '1) cnt_a <= cnt_a + 16'd1;
        2'd1: if (cnt_b != '1) cnt_b <= cnt_b + 16'd1;
        2'd2: if (cnt_c != '1) cnt_c <= cnt_c + 16'd1;
        default: if (cnt_d != '1) cnt_d <= cnt_d + 16'd1;
      endcase
    end
  end
`endif

endmodule
